// File: rtl/psram_seq_pkg.sv
// Shared types, opcodes and command-list helpers for the PSRAM
// power-up / re-init sequencer.
package psram_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_START = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;
    localparam state_t ST_WAIT  = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

    localparam logic [7:0] CMD_RSTEN  = 8'h66;
    localparam logic [7:0] CMD_RST    = 8'h99;
    localparam logic [7:0] CMD_QPI_EN = 8'h35;
    localparam logic [7:0] CMD_QPI_EX = 8'hF5;

    typedef struct packed {
        logic [7:0] opcode;
        logic       qpi;
        logic       wait_after;
    } cmd_t;

    localparam logic [1:0] IDX_QPI_EX = 2'd0;
    localparam logic [1:0] IDX_RSTEN  = 2'd1;
    localparam logic [1:0] IDX_RST    = 2'd2;
    localparam logic [1:0] IDX_QPI_EN = 2'd3;

    function automatic cmd_t cmd_entry(input logic [1:0] idx);
        cmd_t c;
        case (idx)
            IDX_QPI_EX: c = '{opcode: CMD_QPI_EX, qpi: 1'b1, wait_after: 1'b0};
            IDX_RSTEN:  c = '{opcode: CMD_RSTEN,  qpi: 1'b0, wait_after: 1'b0};
            IDX_RST:    c = '{opcode: CMD_RST,    qpi: 1'b0, wait_after: 1'b1};
            default:    c = '{opcode: CMD_QPI_EN, qpi: 1'b0, wait_after: 1'b0};
        endcase
        return c;
    endfunction

    // SPI: one bit on dout[0], MSB first. QPI: high nibble then low.
    function automatic logic [3:0] cmd_symbol(
        input logic [7:0] op,
        input logic       qpi,
        input logic [2:0] idx
    );
        if (qpi)
            return idx[0] ? op[3:0] : op[7:4];
        return {3'b000, op[3'd7 - idx]};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/psram_cmd_shifter.sv
// Drives one PSRAM command (SPI or QPI) onto the pins: setup, shift
// of all symbols, one hold cycle, then raises CE_n and pulses o_done.
module psram_cmd_shifter
    import psram_seq_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int CW      = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_start,
    input  logic [7:0] i_opcode,
    input  logic       i_qpi,
    output logic       o_sck,
    output logic       o_ce_n,
    output logic [3:0] o_dout,
    output logic [3:0] o_douten,
    output logic       o_done
);

    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_op;
    logic          r_qpi;
    logic          r_sck;
    logic          r_ce_n;
    logic [3:0]    r_dout;
    logic [3:0]    r_douten;
    logic          r_done;

    logic          w_cnt_zero;
    logic          w_bit_last;
    logic [2:0]    w_bit_next;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_bit_last = (r_bit == (r_qpi ? 3'd1 : 3'd7));
    assign w_bit_next = r_bit + 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_START;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_op     <= '0;
            r_qpi    <= 1'b0;
            r_sck    <= 1'b0;
            r_ce_n   <= 1'b1;
            r_dout   <= '0;
            r_douten <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= DIV_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_sck) begin
                        r_sck <= 1'b1;
                        r_cnt <= DIV_LOAD;
                    end else if (w_bit_last) begin
                        r_sck   <= 1'b0;
                        r_bit   <= '0;
                        r_state <= ST_HOLD;
                    end else begin
                        // next symbol only on the falling SCK edge
                        r_sck  <= 1'b0;
                        r_bit  <= w_bit_next;
                        r_dout <= cmd_symbol(r_op, r_qpi, w_bit_next);
                        r_cnt  <= DIV_LOAD;
                    end
                end
                ST_HOLD: begin
                    r_ce_n   <= 1'b1;
                    r_dout   <= '0;
                    r_douten <= '0;
                    r_done   <= 1'b1;
                    r_state  <= ST_START;
                end
                default: begin
                    if (i_start) begin
                        r_state  <= ST_SETUP;
                        r_cnt    <= DIV_LOAD;
                        r_bit    <= '0;
                        r_op     <= i_opcode;
                        r_qpi    <= i_qpi;
                        r_ce_n   <= 1'b0;
                        r_sck    <= 1'b0;
                        r_dout   <= cmd_symbol(i_opcode, i_qpi, 3'd0);
                        r_douten <= i_qpi ? 4'hF : 4'h1;
                    end
                end
            endcase
        end
    end

    assign o_sck    = r_sck;
    assign o_ce_n   = r_ce_n;
    assign o_dout   = r_dout;
    assign o_douten = r_douten;
    assign o_done   = r_done;

endmodule

// File: rtl/psram_qpi_init_seq.sv
// PSRAM power-up / re-init sequencer: walks the command list, then
// hands the pins and the APB handshake over to the controller.
module psram_qpi_init_seq
    import psram_seq_pkg::*;
#(
    parameter int CLK_DIV         = 1,
    parameter int RST_WAIT_CYCLES = 64,
    parameter int GAP_CYCLES      = 4,
    parameter int ENABLE_RESET    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ctrl_sck,
    input  logic       ctrl_ce_n,
    input  logic [3:0] ctrl_dout,
    input  logic [3:0] ctrl_douten,
    output logic       qspi_sck,
    output logic       qspi_ce_n,
    output logic [3:0] qspi_dout,
    output logic [3:0] qspi_douten,
    input  logic       apb_psel_in,
    input  logic       apb_pready_in,
    output logic       apb_psel_out,
    output logic       apb_pready_out,
    input  logic       reinit_req,
    output logic       init_done
);

    localparam int CW =
        $clog2(max3(CLK_DIV, GAP_CYCLES, RST_WAIT_CYCLES) + 1);
    // GAP is entered one cycle after CE_n already rose
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 2);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(RST_WAIT_CYCLES - 1);
    localparam logic [1:0] FIRST_IDX =
        (ENABLE_RESET != 0) ? IDX_RSTEN : IDX_QPI_EN;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic          r_wait;
    logic          r_pending;
    logic          r_init_done;

    logic          w_cnt_zero;
    logic          w_last;
    logic          w_take;
    logic          w_start;
    logic [1:0]    w_next_idx;
    logic [1:0]    w_start_idx;
    cmd_t          w_start_cmd;

    logic          w_seq_sck;
    logic          w_seq_ce_n;
    logic [3:0]    w_seq_dout;
    logic [3:0]    w_seq_douten;
    logic          w_cmd_done;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_last     = (r_idx == IDX_QPI_EN);
    assign w_take     = (r_state == ST_DONE) && r_pending
                        && ctrl_ce_n && !apb_psel_in;
    assign w_next_idx = (r_idx == IDX_QPI_EX) ? FIRST_IDX
                                              : r_idx + 2'd1;

    always_comb begin
        w_start     = 1'b0;
        w_start_idx = w_next_idx;
        case (r_state)
            ST_START: begin
                w_start     = 1'b1;
                w_start_idx = FIRST_IDX;
            end
            ST_GAP:  w_start = w_cnt_zero && !r_wait && !w_last;
            ST_WAIT: w_start = w_cnt_zero;
            ST_DONE: begin
                w_start     = w_take;
                w_start_idx = IDX_QPI_EX;
            end
            default: w_start = 1'b0;
        endcase
        w_start_cmd = cmd_entry(w_start_idx);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_START;
            r_cnt       <= '0;
            r_idx       <= IDX_QPI_EX;
            r_wait      <= 1'b0;
            r_pending   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_pending <= reinit_req | (r_pending & ~w_take);
            if (w_start) begin
                r_idx  <= w_start_idx;
                r_wait <= w_start_cmd.wait_after;
            end
            case (r_state)
                ST_START: r_state <= ST_SETUP;
                ST_SETUP: begin
                    if (w_cmd_done) begin
                        r_state <= ST_GAP;
                        r_cnt   <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_wait) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= WAIT_LOAD;
                    end else if (w_last) begin
                        r_state     <= ST_DONE;
                        r_init_done <= 1'b1;
                    end else begin
                        r_state <= ST_SETUP;
                    end
                end
                ST_WAIT: begin
                    if (w_cnt_zero)
                        r_state <= ST_SETUP;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                ST_DONE: begin
                    if (w_take) begin
                        r_state     <= ST_SETUP;
                        r_init_done <= 1'b0;
                    end
                end
                default: r_state <= ST_START;
            endcase
        end
    end

    psram_cmd_shifter #(
        .CLK_DIV (CLK_DIV),
        .CW      (CW)
    ) u_shifter (
        .clock    (clock),
        .reset    (reset),
        .i_start  (w_start),
        .i_opcode (w_start_cmd.opcode),
        .i_qpi    (w_start_cmd.qpi),
        .o_sck    (w_seq_sck),
        .o_ce_n   (w_seq_ce_n),
        .o_dout   (w_seq_dout),
        .o_douten (w_seq_douten),
        .o_done   (w_cmd_done)
    );

    assign qspi_sck       = r_init_done ? ctrl_sck    : w_seq_sck;
    assign qspi_ce_n      = r_init_done ? ctrl_ce_n   : w_seq_ce_n;
    assign qspi_dout      = r_init_done ? ctrl_dout   : w_seq_dout;
    assign qspi_douten    = r_init_done ? ctrl_douten : w_seq_douten;
    assign apb_psel_out   = r_init_done & apb_psel_in;
    assign apb_pready_out = r_init_done & apb_pready_in;
    assign init_done      = r_init_done;

endmodule

// File: tb/tb_psram_qpi_init_seq.sv
// Scoreboard bench: expected CE_n windows are queued by the stimulus
// thread and checked by a pin monitor as each window closes.
`timescale 1ns/1ps
module tb_psram_qpi_init_seq;

    localparam int GAP   = 4;
    localparam int WAITC = 64;

    typedef struct {
        logic [7:0] op;
        bit         qpi;
        int         len;
        int         rises;
        int         gap;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_a, rst_b;
    logic       ctrl_sck, ctrl_ce_n;
    logic [3:0] ctrl_dout, ctrl_douten;
    logic       psel_in, pready_in, reinit_a;
    logic       lo;

    logic       a_sck, a_ce_n, a_psel, a_pready, a_done;
    logic [3:0] a_dout, a_oe;
    logic       b_sck, b_ce_n, b_psel, b_pready, b_done;
    logic [3:0] b_dout, b_oe;

    psram_qpi_init_seq #(
        .CLK_DIV(1), .RST_WAIT_CYCLES(WAITC),
        .GAP_CYCLES(GAP), .ENABLE_RESET(1)
    ) dut_a (
        .clock(clock), .reset(rst_a),
        .ctrl_sck(ctrl_sck), .ctrl_ce_n(ctrl_ce_n),
        .ctrl_dout(ctrl_dout), .ctrl_douten(ctrl_douten),
        .qspi_sck(a_sck), .qspi_ce_n(a_ce_n),
        .qspi_dout(a_dout), .qspi_douten(a_oe),
        .apb_psel_in(psel_in), .apb_pready_in(pready_in),
        .apb_psel_out(a_psel), .apb_pready_out(a_pready),
        .reinit_req(reinit_a), .init_done(a_done)
    );

    psram_qpi_init_seq #(
        .CLK_DIV(2), .RST_WAIT_CYCLES(WAITC),
        .GAP_CYCLES(GAP), .ENABLE_RESET(0)
    ) dut_b (
        .clock(clock), .reset(rst_b),
        .ctrl_sck(ctrl_sck), .ctrl_ce_n(ctrl_ce_n),
        .ctrl_dout(ctrl_dout), .ctrl_douten(ctrl_douten),
        .qspi_sck(b_sck), .qspi_ce_n(b_ce_n),
        .qspi_dout(b_dout), .qspi_douten(b_oe),
        .apb_psel_in(lo), .apb_pready_in(lo),
        .apb_psel_out(b_psel), .apb_pready_out(b_pready),
        .reinit_req(lo), .init_done(b_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    exp_t qa[$];
    exp_t qb[$];

    bit         inw[2];
    int         len[2], rises[2], fall_c[2], end_c[2];
    int         last_rise[2], spmin[2], spmax[2], wins[2];
    logic [7:0] sh[2];
    logic [3:0] oe_and[2], oe_or[2];
    bit         hi_bad[2];
    logic       psck[2], pdone[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            inw[i] = 0; end_c[i] = -1; wins[i] = 0;
            psck[i] = 0; pdone[i] = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] op, input bit qpi,
                                input int div, input int gap);
        exp_t e;
        e.op    = op;
        e.qpi   = qpi;
        e.len   = qpi ? 5 * div + 1 : 17 * div + 1;
        e.rises = qpi ? 2 : 8;
        e.gap   = gap;
        return e;
    endfunction

    task automatic push_powerup_a(input int first_gap);
        qa.push_back(mk(8'h66, 0, 1, first_gap));
        qa.push_back(mk(8'h99, 0, 1, GAP));
        qa.push_back(mk(8'h35, 0, 1, GAP + WAITC));
    endtask

    task automatic mon(input int id, input logic rst, input logic ce_n,
                       input logic sck, input logic [3:0] dout,
                       input logic [3:0] oe, input logic done);
        exp_t e;
        bit   ok, have;
        int   sp;
        if (rst) begin
            inw[id] = 0; wins[id] = 0; end_c[id] = -1;
            psck[id] = 0; pdone[id] = 0;
            return;
        end
        sp = (id == 0) ? 2 : 4;
        if (!done && !ce_n) begin
            if (!inw[id]) begin
                inw[id] = 1; len[id] = 0; rises[id] = 0; sh[id] = 0;
                oe_and[id] = 4'hF; oe_or[id] = 0; hi_bad[id] = 0;
                spmin[id] = 1000000; spmax[id] = 0; fall_c[id] = cyc;
            end
            len[id]++;
            oe_and[id] &= oe;
            oe_or[id]  |= oe;
            if (oe != 4'hF && dout[3:1] != 3'b000) hi_bad[id] = 1;
            if (sck && !psck[id]) begin
                if (rises[id] > 0) begin
                    if (cyc - last_rise[id] < spmin[id])
                        spmin[id] = cyc - last_rise[id];
                    if (cyc - last_rise[id] > spmax[id])
                        spmax[id] = cyc - last_rise[id];
                end
                last_rise[id] = cyc;
                rises[id]++;
                sh[id] = (oe == 4'hF) ? {sh[id][3:0], dout}
                                      : {sh[id][6:0], dout[0]};
            end
        end else if (inw[id] && ce_n && !done) begin
            inw[id] = 0;
            wins[id]++;
            n_cmp++;
            have = (id == 0) ? (qa.size() > 0) : (qb.size() > 0);
            if (!have) begin
                n_bad++;
                $display("FAIL win%0d unexpected: op %h len %0d", id,
                         sh[id], len[id]);
            end else begin
                if (id == 0) e = qa.pop_front();
                else         e = qb.pop_front();
                ok = (sh[id] == e.op) && (len[id] == e.len)
                  && (rises[id] == e.rises)
                  && (e.gap < 0 || fall_c[id] - end_c[id] == e.gap)
                  && (spmin[id] == sp && spmax[id] == sp)
                  && (e.qpi ? oe_and[id] == 4'hF
                            : (oe_and[id] == 4'h1 && oe_or[id] == 4'h1
                               && !hi_bad[id]));
                if (!ok)
                    $display({"FAIL win%0d: got op %h len %0d rises %0d",
                              " gap %0d oe %h/%h sp %0d-%0d; want op %h",
                              " len %0d rises %0d gap %0d sp %0d"},
                             id, sh[id], len[id], rises[id],
                             fall_c[id] - end_c[id], oe_and[id],
                             oe_or[id], spmin[id], spmax[id], e.op,
                             e.len, e.rises, e.gap, sp);
                if (!ok) n_bad++;
            end
            end_c[id] = cyc;
        end
        if (done && !pdone[id]) begin
            n_cmp++;
            if (cyc - end_c[id] != GAP) begin
                n_bad++;
                $display("FAIL done_delay%0d: got %0d want %0d", id,
                         cyc - end_c[id], GAP);
            end
        end
        psck[id]  = sck;
        pdone[id] = done;
    endtask

    always @(negedge clock) begin
        cyc = cyc + 1;
        mon(0, rst_a, a_ce_n, a_sck, a_dout, a_oe, a_done);
        mon(1, rst_b, b_ce_n, b_sck, b_dout, b_oe, b_done);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_idle_a(input int budget, input string name);
        int k = 0;
        while (!(a_done && qa.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        check(name, {31'd0, (a_done && qa.size() == 0)}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int  k;
        bit  bad;
        rst_a = 1; rst_b = 1; lo = 0;
        ctrl_sck = 0; ctrl_ce_n = 1; ctrl_dout = 0; ctrl_douten = 0;
        psel_in = 0; pready_in = 1; reinit_a = 0;
        tick(3);
        check("rst_ce_n", {31'd0, a_ce_n}, 1);
        check("rst_sck", {31'd0, a_sck}, 0);
        check("rst_oe", {28'd0, a_oe}, 0);
        check("rst_dout", {28'd0, a_dout}, 0);
        check("rst_done", {31'd0, a_done}, 0);
        check("rst_b_ce_n", {31'd0, b_ce_n}, 1);

        push_powerup_a(-1);
        qb.push_back(mk(8'h35, 0, 2, -1));
        rst_a = 0; rst_b = 0;

        tick(2);
        psel_in = 1;
        k = 0; bad = 0;
        while (!a_done && k < 2000) begin
            if (a_psel || a_pready) bad = 1;
            tick();
            k++;
        end
        check("apb_stall", {31'd0, bad}, 0);
        check("powerup_done", {31'd0, a_done}, 1);
        check("apb_psel_pass", {31'd0, a_psel}, 1);
        check("apb_pready_pass", {31'd0, a_pready}, 1);
        pready_in = 0;
        #1;
        check("apb_pready_low", {31'd0, a_pready}, 0);
        tick();
        psel_in = 0; pready_in = 1;
        #1;
        check("apb_psel_low", {31'd0, a_psel}, 0);
        check("powerup_queue", qa.size(), 0);

        k = 0;
        while (!b_done && k < 500) begin
            tick();
            k++;
        end
        check("b_done", {31'd0, b_done}, 1);
        check("b_queue", qb.size(), 0);

        ctrl_sck = 1; ctrl_ce_n = 0; ctrl_dout = 4'hA; ctrl_douten = 4'hC;
        #1;
        check("mux1", {22'd0, a_sck, a_ce_n, a_dout, a_oe}, 32'h2AC);
        ctrl_sck = 0; ctrl_ce_n = 1; ctrl_dout = 4'h5; ctrl_douten = 4'h3;
        #1;
        check("mux2", {22'd0, a_sck, a_ce_n, a_dout, a_oe}, 32'h153);
        ctrl_dout = 0; ctrl_douten = 0;

        tick();
        psel_in = 1; reinit_a = 1;
        tick();
        reinit_a = 0;
        tick(5);
        check("defer_psel", {31'd0, a_done}, 1);
        psel_in = 0; ctrl_ce_n = 0;
        tick(3);
        check("defer_ce", {31'd0, a_done}, 1);
        qa.push_back(mk(8'hF5, 1, 1, -1));
        push_powerup_a(GAP);
        ctrl_ce_n = 1;
        tick();
        check("reinit_fall", {31'd0, a_done}, 0);
        wait_idle_a(2000, "reinit1_done");

        for (int r = 0; r < 2; r++) begin
            qa.push_back(mk(8'hF5, 1, 1, -1));
            push_powerup_a(GAP);
        end
        reinit_a = 1; tick(); reinit_a = 0;
        tick(20);
        reinit_a = 1; tick(); reinit_a = 0;
        tick(5);
        reinit_a = 1; tick(); reinit_a = 0;
        wait_idle_a(4000, "double_reinit_done");
        tick(300);
        check("no_extra_reinit", {31'd0, a_done}, 1);

        rst_a = 1;
        tick();
        rst_a = 0;
        qa.push_back(mk(8'h66, 0, 1, -1));
        k = 0;
        while (!(wins[0] == 1 && inw[0] && rises[0] == 4) && k < 500) begin
            tick();
            k++;
        end
        check("reach_99_bit3", {31'd0, (wins[0] == 1 && inw[0])}, 1);
        check("partial_bits", {28'd0, sh[0][3:0]}, 32'h9);
        rst_a = 1;
        tick();
        check("midrst_ce_n", {31'd0, a_ce_n}, 1);
        check("midrst_sck", {31'd0, a_sck}, 0);
        check("midrst_oe", {28'd0, a_oe}, 0);
        check("midrst_done", {31'd0, a_done}, 0);
        push_powerup_a(-1);
        rst_a = 0;
        wait_idle_a(2000, "restart_done");

        tick(10);
        check("final_qa", qa.size(), 0);
        check("final_qb", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psram_qpi_init_seq.md
Name: psram_qpi_init_seq

Overview:
- Power-up and re-initialisation sequencer for the QSPI PSRAM behind the APB PSRAM bridge.
- After reset it owns the PSRAM pins and issues, in SPI mode: reset-enable (0x66), reset (0x99), a wait, then enter-QPI (0x35).
- While it runs, APB transfers are stalled. When it finishes, the pins and the APB handshake are handed to the Wishbone PSRAM controller.
- A software-triggered re-init first exits QPI (0xF5, sent in QPI format), then repeats the power-up sequence.

Parameters:
- CLK_DIV, 1: SCK half-period in clock cycles (>=1).
- RST_WAIT_CYCLES, 64: idle cycles after the 0x99 CE_n rise, before enter-QPI.
- GAP_CYCLES, 4: minimum CE_n-high cycles between commands and before handover (>=2).
- ENABLE_RESET, 1: 0 skips 0x66/0x99/wait.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ctrl_sck  in  1  controller SCK
- ctrl_ce_n  in  1  controller CE_n
- ctrl_dout  in  4  controller data out
- ctrl_douten  in  4  controller per-bit output enable
- qspi_sck  out  1  to pad
- qspi_ce_n  out  1  to pad
- qspi_dout  out  4  to pad
- qspi_douten  out  4  to pad tristate enable
- apb_psel_in  in  1  APB select from master
- apb_pready_in  in  1  ready from controller wrapper
- apb_psel_out  out  1  select to controller wrapper
- apb_pready_out  out  1  ready to master
- reinit_req  in  1  one-cycle re-init request pulse
- init_done  out  1  high when the controller owns the pins

Behaviour:
- Reset values (registered outputs):
  - sequencer sck=0, ce_n=1, dout=0, douten=0
  - init_done=0, pending=0, state=START
- Pin mux:
  - init_done=1: qspi_* = ctrl_* (combinational).
  - init_done=0: qspi_* = sequencer registers.
- APB gate:
  - init_done=1: apb_psel_out=apb_psel_in and apb_pready_out=apb_pready_in.
  - init_done=0: both forced to 0, so the master stalls holding psel.
- States:
  - START -> SETUP (first cycle out of reset).
  - SETUP: ce_n=0, sck=0 for CLK_DIV cycles.
  - SHIFT: each symbol is CLK_DIV cycles sck=0 then CLK_DIV cycles sck=1. Data changes only on the sck 1->0 transition, or on entry, so it is stable at the rising edge.
  - HOLD: sck=0 for 1 cycle, then ce_n=1.
  - GAP: ce_n=1 for GAP_CYCLES.
  - WAIT: RST_WAIT_CYCLES, entered only after 0x99.
  - DONE: init_done=1.
- SPI symbols:
  - 8 bits, MSB first, on dout[0].
  - douten=4'b0001, dout[3:1]=0.
  - 8 rising SCK edges per command.
- QPI symbols (0xF5 only):
  - 2 nibbles, high nibble first, on dout[3:0].
  - douten=4'b1111, 2 rising SCK edges.
- CE_n-low duration per command:
  - SPI: CLK_DIV + 16*CLK_DIV + 1 cycles.
  - QPI: CLK_DIV + 4*CLK_DIV + 1 cycles.
- Command list:
  - power-up: [0x66, 0x99, WAIT, 0x35], or [0x35] if ENABLE_RESET=0.
  - re-init: 0xF5 (QPI), GAP, then the power-up list.
  - A GAP follows every command. The last GAP leads to DONE.
- Re-init:
  - reinit_req sets pending in any state; a second pulse while pending is absorbed.
  - Pending is taken in DONE only when ctrl_ce_n=1 and apb_psel_in=0 in the same cycle.
  - Next cycle: init_done=0, pending cleared, state=SETUP with the 0xF5 command.
  - If a request arrives while the sequence is running, it runs again after DONE (pending stays set).
- Reset mid-command:
  - Next edge forces ce_n=1, sck=0, douten=0, init_done=0.
  - Full power-up sequence restarts. No partial command is resumed.
- Counters:
  - Phase counter is ceil(log2(max(CLK_DIV, GAP_CYCLES, RST_WAIT_CYCLES)+1)) bits.
  - Bit index is 3 bits and wraps only at the command end.

Decomposition:
- Package psram_seq_pkg holds:
  - state enum
  - command constants: CMD_RSTEN=0x66, CMD_RST=0x99, CMD_QPI_EN=0x35, CMD_QPI_EX=0xF5
  - command-list entry struct: opcode, qpi flag, wait-after flag
- One sub-module, psram_cmd_shifter, does setup/shift/hold of one command (SPI or QPI) from a start pulse and reports a done pulse. The top module holds the list FSM, gap/wait counters, mux and APB gate.

Test Plan:
- Power-up, CLK_DIV=1, ENABLE_RESET=1 -> three CE_n-low windows of 18 cycles each.
  - dout[0] sampled on the SCK rises gives 0x66, 0x99, 0x35.
  - Window 2 to window 3 gap is RST_WAIT_CYCLES+GAP_CYCLES.
  - init_done rises GAP_CYCLES after the last CE_n rise.
- APB read issued at cycle 2 -> apb_psel_out=0 and apb_pready_out=0 until init_done. Then the transfer completes through the controller with correct data.
- ENABLE_RESET=0, CLK_DIV=2 -> single CE_n window of 35 cycles, 8 SCK rises 4 cycles apart, data 0x35.
- reinit_req pulse while apb_psel_in=1 -> deferred.
  - After psel drops and ctrl_ce_n=1, init_done falls.
  - QPI window with nibbles 0xF, 0x5 and douten=0xF, then 0x66/0x99/0x35 again.
- Reset asserted mid-0x99 (bit 3) -> next cycle ce_n=1, douten=0, init_done=0. The sequence restarts with 0x66.
- Two reinit_req pulses during a running re-init -> exactly one additional re-init after DONE.
